// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of every handshake and bus signal around mem_arbiter.
//
// Parameter:
//   RAM_ADDR_BITS : word-address width driven to the single-port memory.
//
// Signal groups:
//   fetch port  : inst_req_F, pc_F -> inst_F, inst_mem_ack_F
//   data port   : data_req_M, mem_write_M, alu_out_M, write_data_M
//                 -> read_data_M, data_mem_ack_M
//   memory side : wr_en, addr, data_in -> ; mem_out <- (1-cycle registered read)
//
// Modports:
//   slave  : the arbiter's view (requests and mem_out in; acks, data and RAM controls out)
//   master : the surrounding pipeline + memory view (the mirror image)
interface mem_arbiter_if #(
    parameter int RAM_ADDR_BITS = 8
);
    logic                     inst_req_F;
    logic [31:0]              pc_F;
    logic [31:0]              inst_F;
    logic                     inst_mem_ack_F;
    logic                     data_req_M;
    logic                     mem_write_M;
    logic [31:0]              alu_out_M;
    logic [31:0]              write_data_M;
    logic [31:0]              read_data_M;
    logic                     data_mem_ack_M;
    logic                     wr_en;
    logic [RAM_ADDR_BITS-1:0] addr;
    logic [31:0]              data_in;
    logic [31:0]              mem_out;

    modport slave (
        input  inst_req_F, pc_F, data_req_M, mem_write_M, alu_out_M, write_data_M, mem_out,
        output inst_F, inst_mem_ack_F, read_data_M, data_mem_ack_M, wr_en, addr, data_in
    );

    modport master (
        output inst_req_F, pc_F, data_req_M, mem_write_M, alu_out_M, write_data_M, mem_out,
        input  inst_F, inst_mem_ack_F, read_data_M, data_mem_ack_M, wr_en, addr, data_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one single-port, 1-cycle-latency memory between the
// instruction-fetch port and the data (load/store) port.
//
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : mem_arbiter_if.slave (fetch port, data port, memory controls)
//
// Operation: the grant is combinational in cycle N (addr/wr_en/data_in are
// driven directly); the granted requester is acked in cycle N+1, when the
// memory's registered read data is forwarded. A requester is never granted in
// its own ack cycle because its request still refers to the finished access.
//
// Configuration macro MEM_ARB_RR_EN:
//   undefined : fixed priority, data port beats fetch port.
//   defined   : round-robin on simultaneous requests, tracked by rr_last.
module mem_arbiter #(
    parameter int RAM_ADDR_BITS = 8
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ACK_NONE = 2'd0,
        ACK_INST = 2'd1,
        ACK_DATA = 2'd2
    } ack_e;

    ack_e last_ack_q, last_ack_d;

`ifdef MEM_ARB_RR_EN
    // 0 = fetch port was granted last, 1 = data port was granted last.
    logic rr_last_q, rr_last_d;
`endif

    logic inst_elig, data_elig;
    logic grant_inst, grant_data;
    logic inst_ack, data_ack;

    // Bits outside the word-address window are ignored (addresses wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.pc_F[31:RAM_ADDR_BITS+2], bus.pc_F[1:0],
                                bus.alu_out_M[31:RAM_ADDR_BITS+2], bus.alu_out_M[1:0]};

    always_comb begin
        // Acks come from the registered state but are masked while reset is
        // high, so a reset in the cycle after a grant kills that ack.
        inst_ack  = (last_ack_q == ACK_INST) && !reset;
        data_ack  = (last_ack_q == ACK_DATA) && !reset;

        inst_elig = bus.inst_req_F && (last_ack_q != ACK_INST);
        data_elig = bus.data_req_M && (last_ack_q != ACK_DATA);

`ifdef MEM_ARB_RR_EN
        if (inst_elig && data_elig) begin
            grant_data = !rr_last_q;
            grant_inst = rr_last_q;
        end else begin
            grant_data = data_elig;
            grant_inst = inst_elig;
        end
`else
        grant_data = data_elig;
        grant_inst = inst_elig && !data_elig;
`endif
        grant_data = grant_data && !reset;
        grant_inst = grant_inst && !reset;

        bus.addr    = grant_data ? bus.alu_out_M[RAM_ADDR_BITS+1:2]
                                 : bus.pc_F[RAM_ADDR_BITS+1:2];
        bus.wr_en   = grant_data && bus.mem_write_M;
        bus.data_in = bus.wr_en ? bus.write_data_M : 32'd0;

        bus.inst_mem_ack_F = inst_ack;
        bus.data_mem_ack_M = data_ack;
        bus.inst_F         = inst_ack ? bus.mem_out : 32'd0;
        bus.read_data_M    = data_ack ? bus.mem_out : 32'd0;

        last_ack_d = ACK_NONE;
        if (grant_data) begin
            last_ack_d = ACK_DATA;
        end else if (grant_inst) begin
            last_ack_d = ACK_INST;
        end

`ifdef MEM_ARB_RR_EN
        rr_last_d = rr_last_q;
        if (grant_data) begin
            rr_last_d = 1'b1;
        end else if (grant_inst) begin
            rr_last_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_ack_q <= ACK_NONE;
`ifdef MEM_ARB_RR_EN
            rr_last_q  <= 1'b0;
`endif
        end else begin
            last_ack_q <= last_ack_d;
`ifdef MEM_ARB_RR_EN
            rr_last_q  <= rr_last_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- scoreboard bench for mem_arbiter. The stimulus process
// pushes the expected ack (port + data) when it issues a request; a monitor
// on the falling edge pops and compares whenever an ack appears.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.RAM_ADDR_BITS(8)) bus ();

    mem_arbiter #(.RAM_ADDR_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Single-port memory: registered read, read data held on write cycles.
    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (bus.wr_en) ram[bus.addr] <= bus.data_in;
        else           bus.mem_out   <= ram[bus.addr];
    end

`ifdef MEM_ARB_RR_EN
    localparam bit RR_BUILD = 1'b1;
`else
    localparam bit RR_BUILD = 1'b0;
`endif

    typedef struct {
        bit          is_data;
        bit          chk_data;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard checker.
    always @(negedge clk) begin
        if (bus.inst_mem_ack_F || bus.data_mem_ack_M) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got inst=%0b data=%0b expected none",
                         bus.inst_mem_ack_F, bus.data_mem_ack_M);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("ack_port", {31'd0, bus.data_mem_ack_M}, {31'd0, e.is_data});
                if (e.chk_data)
                    chk("ack_data", e.is_data ? bus.read_data_M : bus.inst_F, e.data);
                $display("ack port=%s data=%h", e.is_data ? "data" : "inst",
                         e.is_data ? bus.read_data_M : bus.inst_F);
            end
        end
        if (!bus.inst_mem_ack_F) chk("inst_F_idle_zero", bus.inst_F, 32'd0);
        if (!bus.data_mem_ack_M) chk("read_data_idle_zero", bus.read_data_M, 32'd0);
    end

    // One isolated access: grant checks in N, latency check in N+1.
    task automatic single(input bit is_data, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [7:0] ea,
                          input logic [31:0] ed);
        if (is_data) begin
            bus.data_req_M   = 1'b1;
            bus.mem_write_M  = wr;
            bus.alu_out_M    = a;
            bus.write_data_M = wd;
        end else begin
            bus.inst_req_F = 1'b1;
            bus.pc_F       = a;
        end
        #2;
        chk("grant_addr", {24'd0, bus.addr}, {24'd0, ea});
        chk("grant_wr_en", {31'd0, bus.wr_en}, {31'd0, wr});
        chk("grant_data_in", bus.data_in, wr ? wd : 32'd0);
        sb_q.push_back('{is_data, !wr, ed});
        tick();
        bus.inst_req_F = 1'b0;
        bus.data_req_M = 1'b0;
        #2;
        chk("ack_latency", {31'd0, is_data ? bus.data_mem_ack_M : bus.inst_mem_ack_F}, 32'd1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'd0;
        ram[0]  = 32'h11110000;
        ram[4]  = 32'h2002000A;
        ram[12] = 32'h0C0C0C0C;
        ram[16] = 32'h55AA55AA;
        bus.mem_out = 32'd0;

        // Reset with a store pending: it must never reach the memory.
        reset            = 1'b1;
        bus.inst_req_F   = 1'b0;
        bus.pc_F         = 32'd0;
        bus.data_req_M   = 1'b1;
        bus.mem_write_M  = 1'b1;
        bus.alu_out_M    = 32'h30;
        bus.write_data_M = 32'hBADBAD00;
        for (int i = 0; i < 3; i++) begin
            tick();
            #2;
            chk("reset_wr_en", {31'd0, bus.wr_en}, 32'd0);
            chk("reset_acks", {30'd0, bus.inst_mem_ack_F, bus.data_mem_ack_M}, 32'd0);
        end
        bus.data_req_M  = 1'b0;
        bus.mem_write_M = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        #2;
        chk("idle_addr_is_pc", {24'd0, bus.addr}, 32'd0);
        chk("idle_data_in", bus.data_in, 32'd0);
        tick();

        // Fetch 0x10 -> word 4.
        single(1'b0, 1'b0, 32'h10, 32'd0, 8'd4, 32'h2002000A);

        // Sustained fetch: grant, ack, grant, ack.
        bus.inst_req_F = 1'b1;
        bus.pc_F       = 32'h10;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.inst_req_F = 1'b0;
            #2;
            chk("sustained_ack", {31'd0, bus.inst_mem_ack_F}, i % 2);
            if (i % 2 == 0) sb_q.push_back('{1'b0, 1'b1, 32'h2002000A});
            tick();
        end

        // Store then load back, wrap, and a store that was blocked by reset.
        single(1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 8'd8, 32'd0);
        single(1'b1, 1'b0, 32'h20, 32'd0, 8'd8, 32'hDEADBEEF);
        single(1'b1, 1'b0, 32'h30, 32'd0, 8'd12, 32'h0C0C0C0C);
        single(1'b1, 1'b0, 32'h403, 32'd0, 8'd0, 32'h11110000);

        // Simultaneous fetch 0x0 and load 0x40 (last grant was data).
        bus.inst_req_F  = 1'b1;
        bus.pc_F        = 32'h0;
        bus.data_req_M  = 1'b1;
        bus.mem_write_M = 1'b0;
        bus.alu_out_M   = 32'h40;
        #2;
        chk("simul_first_addr", {24'd0, bus.addr}, RR_BUILD ? 32'h00 : 32'h10);
        sb_q.push_back(RR_BUILD ? '{1'b0, 1'b1, 32'h11110000} : '{1'b1, 1'b1, 32'h55AA55AA});
        tick();
        #2;
        chk("simul_second_addr", {24'd0, bus.addr}, RR_BUILD ? 32'h10 : 32'h00);
        sb_q.push_back(RR_BUILD ? '{1'b1, 1'b1, 32'h55AA55AA} : '{1'b0, 1'b1, 32'h11110000});
        tick();
        bus.inst_req_F = 1'b0;
        bus.data_req_M = 1'b0;
        #2;
        chk("simul_second_ack", {30'd0, bus.inst_mem_ack_F, bus.data_mem_ack_M},
            RR_BUILD ? 32'd1 : 32'd2);
        tick();

        // Both request; the loser drops before being granted -> one ack only.
        bus.inst_req_F = 1'b1;
        bus.pc_F       = 32'h10;
        bus.data_req_M = 1'b1;
        bus.alu_out_M  = 32'h40;
        #2;
        chk("drop_winner_addr", {24'd0, bus.addr}, RR_BUILD ? 32'h04 : 32'h10);
        sb_q.push_back(RR_BUILD ? '{1'b0, 1'b1, 32'h2002000A} : '{1'b1, 1'b1, 32'h55AA55AA});
        tick();
        bus.inst_req_F = 1'b0;
        bus.data_req_M = 1'b0;
        tick();
        #2;
        chk("dropped_no_ack", {30'd0, bus.inst_mem_ack_F, bus.data_mem_ack_M}, 32'd0);
        tick();

        // Reset in the cycle after a fetch grant: ack suppressed, then fresh grant.
        bus.inst_req_F = 1'b1;
        bus.pc_F       = 32'h10;
        #2;
        chk("rst_grant_addr", {24'd0, bus.addr}, 32'd4);
        tick();
        reset = 1'b1;
        #2;
        chk("rst_ack_killed", {30'd0, bus.inst_mem_ack_F, bus.data_mem_ack_M}, 32'd0);
        chk("rst_inst_F", bus.inst_F, 32'd0);
        chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        tick();
        reset = 1'b0;
        #2;
        chk("post_rst_addr", {24'd0, bus.addr}, 32'd4);
        sb_q.push_back('{1'b0, 1'b1, 32'h2002000A});
        tick();
        bus.inst_req_F = 1'b0;
        #2;
        chk("post_rst_ack", {31'd0, bus.inst_mem_ack_F}, 32'd1);
        tick();

        repeat (3) tick();
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
